regfile_wb: RTL and testbench
=============================

# regfile_wb

Register file and write-back stage for the EEP-style datapath: supplies the ALU's `ra`, `rb` and `flagcin` operands and consumes its `out`, `flagc` and `flagv` results. Results enter a one-entry write-back register through a valid/ready handshake and commit to the architectural registers and NZCV flags one cycle later. Commit can be stalled or flushed. Reads bypass the pending entry, so the ALU always sees the newest value.

## Interface
- `REG_WIDTH`, 16, datapath width; must equal the ALU's `REG_WIDTH`.
- `NREGS`, 8, number of registers; address width is `AW = $clog2(NREGS)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset: asynchronous assert, active-low.
- `rdaddra`  in  AW  read address for port A.
- `rdaddrb`  in  AW  read address for port B.
- `ra`  out  REG_WIDTH  port A data (combinational, bypassed); drives ALU `ra`.
- `rb`  out  REG_WIDTH  port B data (combinational, bypassed); drives ALU `rb`.
- `flagc_out`  out  1  current C flag (bypassed); drives ALU `flagcin`.
- `flags`  out  4  committed flags {N,Z,C,V}; not bypassed.
- `wb_valid`  in  1  a write-back request is presented.
- `wb_ready`  out  1  the stage can accept a request this cycle.
- `wb_addr`  in  AW  destination register.
- `wb_data`  in  REG_WIDTH  result; driven by ALU `out`.
- `wb_we`  in  1  write `wb_data` to `wb_addr`.
- `wb_setflags`  in  1  update NZCV from this result.
- `wb_flagc`  in  1  carry from the ALU's `flagc`.
- `wb_flagv`  in  1  overflow from the ALU's `flagv`.
- `commit_stall`  in  1  hold the pending entry; do not commit.
- `flush`  in  1  discard the pending entry.

## Operation
- State:
  - `regs[NREGS]`
  - `flagreg` {N,Z,C,V}
  - pending entry: `p_valid`, `p_addr`, `p_data`, `p_we`, `p_setf`, `p_n`, `p_z`, `p_c`, `p_v`
- Accept: a handshake occurs when `wb_valid && wb_ready`. On that edge:
  - capture the request into the pending entry and set `p_valid=1`;
  - `p_n = wb_data[REG_WIDTH-1]`;
  - `p_z = (wb_data == 0)`;
  - `p_c = wb_flagc`, `p_v = wb_flagv`.
- Ready: `wb_ready = !flush && (!p_valid || !commit_stall)`. Ready is combinational from `p_valid`, `commit_stall` and `flush` only, never from `wb_valid`.
- Commit: happens on any edge with `p_valid && !commit_stall && !flush`.
  - If `p_we`: `regs[p_addr] <= p_data`.
  - If `p_setf`: `flagreg <= {p_n,p_z,p_c,p_v}`.
  - `p_valid` clears, unless a new accept happens on the same edge; then the new request replaces the pending entry.
- Flush: when `flush=1` on an edge, `p_valid <= 0` and nothing commits. No accept is possible that cycle because `wb_ready=0`.
- Entry with `wb_we=0 && wb_setflags=0`: still handshakes and occupies a slot, but has no effect on commit.
- Read bypass, per port:
  - if `p_valid && p_we && p_addr == rdaddrX`, return `p_data`;
  - otherwise return `regs[rdaddrX]`.
- C bypass: `flagc_out = (p_valid && p_setf) ? p_c : flagreg.C`.
- Out-of-range addresses (`addr >= NREGS` when NREGS is not a power of two): reads return 0; writes are dropped.

## Timing
- Reset, asynchronous on `rst_n=0`:
  - all `regs=0`, `flagreg=0`, `p_valid=0`;
  - therefore `ra=rb=0`, `flags=0`, `flagc_out=0`;
  - `wb_ready=1`, subject to `flush`.
- Reset mid-operation: an uncommitted pending entry is lost.
- Latency:
  - a request accepted at edge t is visible on `ra`/`rb`/`flagc_out` during cycle t+1 via bypass;
  - it is in `regs`/`flags` after edge t+1 if not stalled.
- Back-to-back: one request per cycle is sustained while `commit_stall=0`.
- Stall: while `commit_stall=1` with `p_valid=1`:
  - `wb_ready=0`;
  - the pending entry and bypass hold indefinitely.
- Same address on consecutive requests: the later request wins, both in bypass and in the final register value.
- Flush together with `commit_stall`: flush wins and the entry is dropped.

## Test plan
- Reset then idle:
  - required: `ra=rb=0`, `flags=4'b0000`, `wb_ready=1`.
- Accept {addr=3, data=16'h8000, we=1, setf=1, c=1, v=0}; read A at address 3 in the next cycle:
  - `ra=16'h8000` during the bypass cycle;
  - one edge later, `flags=4'b1010` and `regs[3]=16'h8000`.
- Back-to-back writes to R5, `16'h0001` then `16'h0002`:
  - `rb` shows 1, then 2;
  - final `regs[5]=2`.
- Hold `commit_stall` for 3 cycles with one entry pending:
  - `wb_ready=0` for all 3 cycles;
  - the bypass value holds;
  - commit happens on the first edge after stall release.
- Pending {addr=2, data=16'hFFFF}, then assert `flush`:
  - `regs[2]` keeps its old value;
  - `p_valid=0`, flags unchanged.
- Accept data=0 with setflags, C=0, V=1:
  - after commit, `flags=4'b0101`;
  - `flagc_out` is 0 throughout, taken from bypass.

Source files
------------

// File: rtl/regfile_wb.sv
// regfile_wb: architectural register file, NZCV flag register and a one-entry
// write-back stage for the EEP-style datapath.
//
// Results from the ALU are accepted into a pending entry through a
// valid/ready handshake. They commit to the register file and flags on the
// following edge unless that commit is stalled or flushed. Both read ports
// and the carry output bypass the pending entry, so the ALU always sees the
// newest value.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   rdaddra, rdaddrb     read addresses for ports A and B
//   ra, rb               bypassed read data (combinational)
//   flagc_out            bypassed carry flag, feeds the ALU carry-in
//   flags                committed {N,Z,C,V} (not bypassed)
//   wb_valid, wb_ready   write-back request handshake
//   wb_addr, wb_data     destination register and result
//   wb_we, wb_setflags   write-register / update-flags qualifiers
//   wb_flagc, wb_flagv   carry and overflow from the ALU
//   commit_stall         hold the pending entry
//   flush                discard the pending entry
module regfile_wb #(
    parameter int REG_WIDTH = 16,
    parameter int NREGS     = 8,
    localparam int AW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AW-1:0]        rdaddra,
    input  logic [AW-1:0]        rdaddrb,
    output logic [REG_WIDTH-1:0] ra,
    output logic [REG_WIDTH-1:0] rb,
    output logic                 flagc_out,
    output logic [3:0]           flags,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [AW-1:0]        wb_addr,
    input  logic [REG_WIDTH-1:0] wb_data,
    input  logic                 wb_we,
    input  logic                 wb_setflags,
    input  logic                 wb_flagc,
    input  logic                 wb_flagv,
    input  logic                 commit_stall,
    input  logic                 flush
);

    // Register count widened by one bit so the range check works for
    // non-power-of-two register counts.
    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    logic [REG_WIDTH-1:0] regs [NREGS];
    logic [3:0]           flagreg;

    logic                 p_valid;
    logic [AW-1:0]        p_addr;
    logic [REG_WIDTH-1:0] p_data;
    logic                 p_we;
    logic                 p_setf;
    logic                 p_n;
    logic                 p_z;
    logic                 p_c;
    logic                 p_v;

    logic accept;
    logic commit;
    logic p_addr_ok;
    logic rda_ok;
    logic rdb_ok;

    assign rda_ok    = ({1'b0, rdaddra} < NREGS_W);
    assign rdb_ok    = ({1'b0, rdaddrb} < NREGS_W);
    assign p_addr_ok = ({1'b0, p_addr}  < NREGS_W);

    // Ready never looks at wb_valid, so no combinational loop can form
    // through an upstream stage that waits for ready.
    assign wb_ready = !flush && (!p_valid || !commit_stall);
    assign accept   = wb_valid && wb_ready;
    assign commit   = p_valid && !commit_stall && !flush;

    // Pending entry. A flush blocks accept through wb_ready, so the flush
    // branch only has to drop the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_addr  <= '0;
            p_data  <= '0;
            p_we    <= 1'b0;
            p_setf  <= 1'b0;
            p_n     <= 1'b0;
            p_z     <= 1'b0;
            p_c     <= 1'b0;
            p_v     <= 1'b0;
        end else begin
            if (flush) begin
                p_valid <= 1'b0;
            end else if (accept) begin
                p_valid <= 1'b1;
            end else if (commit) begin
                p_valid <= 1'b0;
            end

            if (accept) begin
                p_addr <= wb_addr;
                p_data <= wb_data;
                p_we   <= wb_we;
                p_setf <= wb_setflags;
                p_n    <= wb_data[REG_WIDTH-1];
                p_z    <= (wb_data == '0);
                p_c    <= wb_flagc;
                p_v    <= wb_flagv;
            end
        end
    end

    // Architectural registers; out-of-range destinations are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && p_we && p_addr_ok) begin
            regs[p_addr] <= p_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flagreg <= '0;
        end else if (commit && p_setf) begin
            flagreg <= {p_n, p_z, p_c, p_v};
        end
    end

    // Read ports: range check first, then pending-entry bypass, then the
    // register file.
    always_comb begin
        ra = '0;
        if (rda_ok) begin
            if (p_valid && p_we && (p_addr == rdaddra)) begin
                ra = p_data;
            end else begin
                ra = regs[rdaddra];
            end
        end
    end

    always_comb begin
        rb = '0;
        if (rdb_ok) begin
            if (p_valid && p_we && (p_addr == rdaddrb)) begin
                rb = p_data;
            end else begin
                rb = regs[rdaddrb];
            end
        end
    end

    assign flagc_out = (p_valid && p_setf) ? p_c : flagreg[1];
    assign flags     = flagreg;

endmodule

// File: tb/tb_regfile_wb.sv
// Testbench for regfile_wb: a directed vector table, a hand-written
// mid-operation reset sequence, and a randomized phase checked against a
// queue-based reference model.
module tb_regfile_wb;

    localparam int RW = 16;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    rdaddra, rdaddrb;
    logic [RW-1:0] ra, rb;
    logic          flagc_out;
    logic [3:0]    flags;
    logic          wb_valid, wb_ready;
    logic [2:0]    wb_addr;
    logic [RW-1:0] wb_data;
    logic          wb_we, wb_setflags, wb_flagc, wb_flagv;
    logic          commit_stall, flush;

    regfile_wb #(.REG_WIDTH(RW), .NREGS(NR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdaddra      (rdaddra),
        .rdaddrb      (rdaddrb),
        .ra           (ra),
        .rb           (rb),
        .flagc_out    (flagc_out),
        .flags        (flags),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_we        (wb_we),
        .wb_setflags  (wb_setflags),
        .wb_flagc     (wb_flagc),
        .wb_flagv     (wb_flagv),
        .commit_stall (commit_stall),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] a, input logic [RW-1:0] d,
                         input logic we, input logic sf, input logic c, input logic ov,
                         input logic st, input logic fl,
                         input logic [2:0] rda, input logic [2:0] rdb);
        wb_valid     = v;
        wb_addr      = a;
        wb_data      = d;
        wb_we        = we;
        wb_setflags  = sf;
        wb_flagc     = c;
        wb_flagv     = ov;
        commit_stall = st;
        flush        = fl;
        rdaddra      = rda;
        rdaddrb      = rdb;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          v;
        logic [2:0]    a;
        logic [RW-1:0] d;
        logic          we, sf, c, ov, st, fl;
        logic [2:0]    rda, rdb;
        logic [RW-1:0] ea, eb;
        logic [3:0]    ef;
        logic          efc, erdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [2:0] a, input logic [RW-1:0] d,
                       input logic we, input logic sf, input logic c, input logic ov,
                       input logic st, input logic fl,
                       input logic [2:0] rda, input logic [2:0] rdb,
                       input logic [RW-1:0] ea, input logic [RW-1:0] eb,
                       input logic [3:0] ef, input logic efc, input logic erdy);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.we = we; r.sf = sf; r.c = c; r.ov = ov;
        r.st = st; r.fl = fl; r.rda = rda; r.rdb = rdb;
        r.ea = ea; r.eb = eb; r.ef = ef; r.efc = efc; r.erdy = erdy;
        tbl.push_back(r);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]    addr;
        logic [RW-1:0] data;
        logic          we, setf, c, v;
    } ent_t;

    ent_t          pend[$];
    logic [RW-1:0] m_regs [NR];
    logic [3:0]    m_flags;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_flags = '0;
        pend.delete();
    endtask

    function automatic logic [RW-1:0] m_read(input logic [2:0] a);
        if (pend.size() > 0 && pend[0].we && pend[0].addr == a) return pend[0].data;
        return m_regs[a];
    endfunction

    function automatic logic m_carry();
        if (pend.size() > 0 && pend[0].setf) return pend[0].c;
        return m_flags[1];
    endfunction

    function automatic logic m_ready();
        if (flush) return 1'b0;
        return (pend.size() == 0) || !commit_stall;
    endfunction

    // Applies what the coming clock edge must do, given the current inputs.
    task automatic model_edge();
        logic rdy;
        logic cm;
        ent_t e;
        rdy = m_ready();
        cm  = (pend.size() > 0) && !commit_stall && !flush;
        if (cm) begin
            e = pend.pop_front();
            if (e.we) m_regs[e.addr] = e.data;
            if (e.setf) m_flags = {e.data[RW-1], e.data == 0, e.c, e.v};
        end
        if (flush) pend.delete();
        else if (wb_valid && rdy) begin
            e.addr = wb_addr; e.data = wb_data; e.we = wb_we;
            e.setf = wb_setflags; e.c = wb_flagc; e.v = wb_flagv;
            pend.push_back(e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //   v a  data      we sf c  v  st fl rda rdb  ea        eb        flags    fc rdy
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'b0000, 0, 1);
        add(1, 3, 16'h8000, 1, 1, 1, 0, 0, 0, 3, 0, 16'h0000, 16'h0000, 4'b0000, 0, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 3, 16'h8000, 16'h8000, 4'b0000, 1, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 0, 16'h8000, 16'h0000, 4'b1010, 1, 1);
        add(1, 5, 16'h0001, 1, 0, 0, 0, 0, 0, 3, 5, 16'h8000, 16'h0000, 4'b1010, 1, 1);
        add(1, 5, 16'h0002, 1, 0, 0, 0, 0, 0, 3, 5, 16'h8000, 16'h0001, 4'b1010, 1, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 5, 5, 16'h0002, 16'h0002, 4'b1010, 1, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 5, 16'h0000, 16'h0002, 4'b1010, 1, 1);
        add(1, 4, 16'h1234, 1, 0, 0, 0, 0, 0, 4, 5, 16'h0000, 16'h0002, 4'b1010, 1, 1);
        add(1, 4, 16'h5555, 1, 0, 0, 0, 1, 0, 4, 5, 16'h1234, 16'h0002, 4'b1010, 1, 0);
        add(1, 4, 16'h5555, 1, 0, 0, 0, 1, 0, 4, 5, 16'h1234, 16'h0002, 4'b1010, 1, 0);
        add(1, 4, 16'h5555, 1, 0, 0, 0, 1, 0, 4, 5, 16'h1234, 16'h0002, 4'b1010, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 4, 5, 16'h1234, 16'h0002, 4'b1010, 1, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 4, 4, 16'h1234, 16'h1234, 4'b1010, 1, 1);
        add(1, 2, 16'hFFFF, 1, 1, 0, 1, 0, 0, 2, 4, 16'h0000, 16'h1234, 4'b1010, 1, 1);
        add(1, 2, 16'h1111, 1, 0, 0, 0, 0, 1, 2, 2, 16'hFFFF, 16'hFFFF, 4'b1010, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 2, 4, 16'h0000, 16'h1234, 4'b1010, 1, 1);
        add(1, 2, 16'h7777, 1, 0, 0, 0, 0, 0, 2, 0, 16'h0000, 16'h0000, 4'b1010, 1, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 2, 2, 16'h7777, 16'h7777, 4'b1010, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 2, 2, 16'h0000, 16'h0000, 4'b1010, 1, 1);
        add(1, 6, 16'h0000, 1, 1, 0, 1, 0, 0, 6, 3, 16'h0000, 16'h8000, 4'b1010, 1, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 6, 6, 16'h0000, 16'h0000, 4'b1010, 0, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 6, 3, 16'h0000, 16'h8000, 4'b0101, 0, 1);
        add(1, 3, 16'hABCD, 0, 0, 1, 1, 0, 0, 3, 5, 16'h8000, 16'h0002, 4'b0101, 0, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 5, 16'h8000, 16'h0002, 4'b0101, 0, 1);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 3, 4, 16'h8000, 16'h1234, 4'b0101, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 2, 16'h8000, 16'h0000, 4'b0101, 0, 1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].sf, tbl[i].c,
                  tbl[i].ov, tbl[i].st, tbl[i].fl, tbl[i].rda, tbl[i].rdb);
            #1;
            chk($sformatf("row%0d ra", i),        32'(ra),        32'(tbl[i].ea));
            chk($sformatf("row%0d rb", i),        32'(rb),        32'(tbl[i].eb));
            chk($sformatf("row%0d flags", i),     32'(flags),     32'(tbl[i].ef));
            chk($sformatf("row%0d flagc_out", i), 32'(flagc_out), 32'(tbl[i].efc));
            chk($sformatf("row%0d wb_ready", i),  32'(wb_ready),  32'(tbl[i].erdy));
        end

        // Reset mid-operation: the pending entry is lost and outputs clear
        // without waiting for a clock edge.
        @(negedge clk);
        drive(1, 1, 16'h4242, 1, 1, 1, 1, 0, 0, 1, 1);
        @(negedge clk);
        drive(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 6);
        #1;
        chk("rst_mid bypass ra", 32'(ra), 32'h4242);
        chk("rst_mid bypass fc", 32'(flagc_out), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async ra", 32'(ra), 32'h0);
        chk("rst_async rb", 32'(rb), 32'h0);
        chk("rst_async flags", 32'(flags), 32'h0);
        chk("rst_async fc", 32'(flagc_out), 32'h0);
        chk("rst_async ready", 32'(wb_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_after ra", 32'(ra), 32'h0);
        chk("rst_after flags", 32'(flags), 32'h0);

        // Randomized phase against the reference model.
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) < 7,
                  3'($urandom_range(0, NR - 1)),
                  ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0,
                  3'($urandom_range(0, NR - 1)),
                  (pend.size() > 0) ? pend[0].addr : 3'($urandom_range(0, NR - 1)));
            #1;
            chk($sformatf("rand%0d ra", cyc),    32'(ra),        32'(m_read(rdaddra)));
            chk($sformatf("rand%0d rb", cyc),    32'(rb),        32'(m_read(rdaddrb)));
            chk($sformatf("rand%0d flags", cyc), 32'(flags),     32'(m_flags));
            chk($sformatf("rand%0d fc", cyc),    32'(flagc_out), 32'(m_carry()));
            chk($sformatf("rand%0d ready", cyc), 32'(wb_ready),  32'(m_ready()));
            model_edge();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
